// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared FSM states, owner encoding and default memory widths
package mem_port_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} stateT;
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;
    localparam int DEF_LINE_W = 128;
    localparam int DEF_ADDR_W = 32;
endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant, ties go to whichever side was not served last
module rr_arb2
    import mem_port_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic reqI,
    input  logic reqD,
    input  logic update,
    input  logic updOwner,
    output logic gntValid,
    output logic gntOwner
);
    logic lastGnt;
    always_ff @(posedge clk)
        if (rst) lastGnt <= OWN_I;
        else if (update) lastGnt <= updOwner;
    assign gntValid = reqI | reqD;
    assign gntOwner = (reqI & reqD) ? ~lastGnt : reqD;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises I-cache and D-cache line transactions onto one memory port
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int LINE_W  = DEF_LINE_W,
    parameter int TIMEOUT = 255
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic [LINE_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_done,
    output logic [LINE_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic              i_stall,
    output logic              d_stall,
    output logic              cache_stall,
    output logic              err
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT);
    stateT state;
    logic owner;
    logic [CW-1:0] wdCount;
    logic gntValid, gntOwner;
    rr_arb2 uArb (
        .clk      (clk),
        .rst      (rst),
        .reqI     (i_req),
        .reqD     (d_req),
        .update   (state == BUSY && mem_ready),
        .updOwner (owner),
        .gntValid (gntValid),
        .gntOwner (gntOwner)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= OWN_I;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_done    <= 1'b0;
            d_done    <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            err       <= 1'b0;
            wdCount   <= '0;
        end else begin
            case (state)
                IDLE: if (gntValid) begin
                    owner     <= gntOwner;
                    mem_req   <= 1'b1;
                    mem_we    <= gntOwner & d_we;
                    mem_addr  <= gntOwner ? d_addr : i_addr;
                    mem_wdata <= gntOwner ? d_wdata : '0;
                    wdCount   <= '0;
                    state     <= BUSY;
                end
                BUSY: if (mem_ready) begin
                    mem_req <= 1'b0;
                    i_done  <= owner == OWN_I;
                    d_done  <= owner == OWN_D;
                    if (owner == OWN_I) i_rdata <= mem_rdata;
                    else if (!mem_we) d_rdata <= mem_rdata;
                    state   <= RESP;
                end else begin
                    // err rises on the edge that completes the TIMEOUT-th stalled BUSY cycle
                    if (wdCount != TMO) wdCount <= wdCount + 1'b1;
                    if (wdCount >= TMO - 1'b1) err <= 1'b1;
                end
                RESP: begin
                    i_done <= 1'b0;
                    d_done <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign i_stall     = i_req & ~i_done;
    assign d_stall     = d_req & ~d_done;
    assign cache_stall = i_stall | d_stall;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed plus random transactions checked against a round-robin reference model
module tb_mem_port_arbiter;
    localparam int ADDR_W = 32;
    localparam int LINE_W = 128;
    localparam int TIMEOUT = 4;
    logic clk = 1'b0;
    logic rst, i_req, d_req, d_we, mem_ready;
    logic [ADDR_W-1:0] i_addr, d_addr;
    logic [LINE_W-1:0] d_wdata, mem_rdata;
    logic i_done, d_done, mem_req, mem_we, i_stall, d_stall, cache_stall, err;
    logic [LINE_W-1:0] i_rdata, d_rdata, mem_wdata;
    logic [ADDR_W-1:0] mem_addr;
    int checks = 0;
    int fails = 0;
    bit lastD;
    bit errExp;
    logic [LINE_W-1:0] expIData, expDData;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .i_stall(i_stall), .d_stall(d_stall), .cache_stall(cache_stall), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [LINE_W-1:0] rnd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic bit expOwner();
        return (i_req && d_req) ? !lastD : d_req;
    endfunction

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        lastD = 1'b0;
        errExp = 1'b0;
        expIData = '0;
        expDData = '0;
    endtask

    // Called at the negedge where the requests the grant depends on are already driven.
    task automatic runTxn(input bit ownD, input int dly, input bit dropEarly);
        logic [ADDR_W-1:0] a;
        logic we;
        logic [LINE_W-1:0] wd, rd;
        a  = ownD ? d_addr : i_addr;
        we = ownD & d_we;
        wd = ownD ? d_wdata : '0;
        rd = '0;
        for (int k = 0; k <= dly; k++) begin
            @(negedge clk);
            if (k >= TIMEOUT) errExp = 1'b1;
            chk("busy_mem_req", mem_req, 1'b1);
            chk("busy_mem_addr", mem_addr, a);
            chk("busy_mem_we", mem_we, we);
            chk("busy_mem_wdata", mem_wdata, wd);
            chk("busy_i_stall", i_stall, i_req);
            chk("busy_d_stall", d_stall, d_req);
            chk("busy_cache_stall", cache_stall, i_req | d_req);
            chk("busy_err", err, errExp);
            chk("busy_done", {i_done, d_done}, 2'b00);
            if (k == 0 && dropEarly) begin
                if (ownD) d_req = 1'b0;
                else i_req = 1'b0;
            end
            if (k == dly) begin
                rd = rnd();
                mem_rdata = rd;
                mem_ready = 1'b1;
            end
        end
        @(negedge clk);
        mem_ready = 1'b0;
        mem_rdata = rnd();
        if (!ownD) expIData = rd;
        else if (!we) expDData = rd;
        lastD = ownD;
        chk("resp_i_done", i_done, !ownD);
        chk("resp_d_done", d_done, ownD);
        chk("resp_i_rdata", i_rdata, expIData);
        chk("resp_d_rdata", d_rdata, expDData);
        chk("resp_mem_req", mem_req, 1'b0);
        chk("resp_i_stall", i_stall, i_req && ownD);
        chk("resp_d_stall", d_stall, d_req && !ownD);
        chk("resp_err", err, errExp);
        if (ownD) d_req = 1'b0;
        else i_req = 1'b0;
        @(negedge clk);
        chk("idle_done", {i_done, d_done}, 2'b00);
        chk("idle_mem_req", mem_req, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        modelReset();
        repeat (2) @(negedge clk);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, '0);
        chk("rst_mem_wdata", mem_wdata, '0);
        chk("rst_done", {i_done, d_done}, 2'b00);
        chk("rst_i_rdata", i_rdata, '0);
        chk("rst_d_rdata", d_rdata, '0);
        chk("rst_err", err, 1'b0);
        chk("rst_stalls", {i_stall, d_stall, cache_stall}, 3'b000);
        rst = 1'b0;
        @(negedge clk);
        // stray mem_ready while idle must be ignored
        mem_ready = 1'b1;
        mem_rdata = rnd();
        @(negedge clk);
        mem_ready = 1'b0;
        chk("stray_done", {i_done, d_done}, 2'b00);
        chk("stray_i_rdata", i_rdata, '0);
        chk("stray_mem_req", mem_req, 1'b0);
        // single I refill
        i_req = 1'b1; i_addr = 32'h100;
        runTxn(expOwner(), 2, 1'b0);
        // simultaneous requests, then D re-requests while I is in flight
        i_req = 1'b1; i_addr = 32'h200;
        d_req = 1'b1; d_addr = 32'h300; d_we = 1'b0; d_wdata = rnd();
        chk("tie_goes_d", expOwner(), 1'b1);
        runTxn(expOwner(), 1, 1'b0);
        d_req = 1'b1; d_addr = 32'h340;
        runTxn(expOwner(), 0, 1'b0);
        runTxn(expOwner(), 0, 1'b0);
        // D write-back leaves d_rdata alone
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h400;
        d_wdata = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
        runTxn(expOwner(), 1, 1'b0);
        d_we = 1'b0;
        // owner withdraws mid-transaction
        i_req = 1'b1; i_addr = 32'h500;
        runTxn(expOwner(), 2, 1'b1);
        @(negedge clk);
        chk("no_regrant", mem_req, 1'b0);
        // watchdog
        i_req = 1'b1; i_addr = 32'h5C0;
        runTxn(expOwner(), 6, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        chk("wd_rst_err", err, 1'b0);
        chk("wd_rst_i_rdata", i_rdata, '0);
        // reset in the middle of a transaction
        d_req = 1'b1; d_addr = 32'h600;
        @(negedge clk);
        chk("abort_busy", mem_req, 1'b1);
        rst = 1'b1; d_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_mem_req", mem_req, 1'b0);
        chk("abort_mem_addr", mem_addr, '0);
        chk("abort_done", {i_done, d_done}, 2'b00);
        @(negedge clk);
        chk("abort_no_done", {i_done, d_done}, 2'b00);
        chk("abort_idle", mem_req, 1'b0);
        i_req = 1'b1; i_addr = 32'h700;
        runTxn(expOwner(), 1, 1'b0);
        // random traffic
        for (int n = 0; n < 40; n++) begin
            if (!i_req && $urandom_range(1) == 1) begin
                i_req = 1'b1;
                i_addr = $urandom & ~32'hF;
            end
            if (!d_req && $urandom_range(1) == 1) begin
                d_req = 1'b1;
                d_addr = $urandom & ~32'hF;
                d_we = 1'($urandom_range(1));
                d_wdata = rnd();
            end
            if (!i_req && !d_req) begin
                i_req = 1'b1;
                i_addr = $urandom & ~32'hF;
            end
            runTxn(expOwner(), int'($urandom_range(2)), $urandom_range(3) == 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single main-memory port between the I-cache refill path and the D-cache refill/write-back path of the 5-stage core.
- Serialises one transaction at a time and returns read data to the owning requester.
- Drives per-cache stall signals plus the combined cache stall consumed by the pipeline hazard logic.
- A watchdog flags a memory transaction that never completes.

Parameters:
ADDR_W, 32, byte address width
LINE_W, 128, cache line / memory data width in bits
TIMEOUT, 255, BUSY cycles without mem_ready before err is set (min 1)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active high
i_req  in  1  I-cache line read request, held until i_done
i_addr  in  ADDR_W  I-cache line address, stable while i_req
i_done  out  1  one-cycle pulse: i_rdata valid, transaction complete
i_rdata  out  LINE_W  line returned to I-cache
d_req  in  1  D-cache request, held until d_done
d_we  in  1  1 = write-back, 0 = refill read
d_addr  in  ADDR_W  D-cache line address
d_wdata  in  LINE_W  write-back line
d_done  out  1  one-cycle pulse: transaction complete (d_rdata valid if read)
d_rdata  out  LINE_W  line returned to D-cache
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  LINE_W  memory write data
mem_ready  in  1  one-cycle completion strobe from memory
mem_rdata  in  LINE_W  read data, valid with mem_ready
i_stall  out  1  i_req & ~i_done
d_stall  out  1  d_req & ~d_done
cache_stall  out  1  i_stall | d_stall
err  out  1  sticky watchdog error

Behaviour:
- Clock is clk. Reset is rst: synchronous, active high.
- FSM states:
  - IDLE: mem_req=0. If exactly one request is high, grant it. If both are high, grant the requester not served last (round-robin via last_gnt). Latch owner, addr, we (0 for I), wdata (0 for I) into registers; go to BUSY.
  - BUSY: mem_req=1. mem_addr/mem_we/mem_wdata are driven from the latched registers and stay stable throughout. On mem_ready: capture mem_rdata into the owner's rdata register, update last_gnt=owner, go to RESP.
  - RESP: assert owner's done for exactly one cycle; the non-owner's done stays 0. Go to IDLE.
- Timing:
  - Minimum transaction is 3 cycles (IDLE grant, BUSY, RESP).
  - A request is never granted in the cycle immediately after its done; the requester must drop req at the edge ending RESP.
- i_rdata/d_rdata hold their last captured value until overwritten. Write-backs do not update d_rdata.
- Requests and input changes during BUSY/RESP are ignored. Deasserting the owner's req mid-transaction does not abort it: the transaction completes and done still pulses.
- Watchdog:
  - A counter clears on entering BUSY and increments each BUSY cycle, saturating.
  - When the count reaches TIMEOUT with no mem_ready, err is set and stays 1 until rst. The FSM keeps waiting.
- mem_ready outside BUSY is ignored.
- Reset values (also on rst mid-transaction, which aborts it without a done pulse):
  - state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - i_done=d_done=0, i_rdata=d_rdata=0, err=0, counter=0.
  - last_gnt=I, so the first tie goes to D.
- Stall outputs are combinational from req and the registered done signals; they are 0 when no req is high.

Decomposition:
- Shared core package holds:
  - state enum {IDLE, BUSY, RESP};
  - owner encoding OWN_I=1'b0, OWN_D=1'b1;
  - default LINE_W/ADDR_W constants shared with the caches.
- Natural sub-module: rr_arb2, a 2-input round-robin grant with last_gnt register and update-enable.
- Watchdog counter stays inline.

Test Plan:
- Single I refill: i_req=1, addr 0x100; mem_ready 2 cycles after mem_req -> mem_addr=0x100, mem_we=0; i_done pulses 1 cycle with i_rdata=mem_rdata; i_stall=1 until i_done; d_done stays 0.
- Tie after reset: i_req and d_req rise the same cycle -> D granted first (mem_addr=d_addr); after d_done, I granted; d_req re-asserted -> I still completes before the next D grant.
- D write-back: d_we=1, d_wdata=0xDEADBEEF_...; mem_ready -> mem_we=1, mem_wdata matches; d_done pulses; d_rdata unchanged.
- Owner drops req during BUSY -> transaction still completes, done pulses once, no second grant.
- mem_ready withheld: TIMEOUT=4 -> err=1 after 4 BUSY cycles and remains 1 after a later mem_ready; rst clears it.
- rst asserted in BUSY -> next cycle mem_req=0, state IDLE, no done pulse; a following request behaves normally.
